// File: rtl/mon_pkg.sv
// Shared helpers for the multi-channel CIC monitor: width derivation and stream states.
package mon_pkg;

    typedef enum logic {StIdle, StSend} stream_state_e;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Channel tag width; a single channel still gets a 1-bit tag.
    function automatic int unsigned chan_w(input int unsigned nchan);
        return (clog2(nchan) > 0) ? clog2(nchan) : 1;
    endfunction

    function automatic int unsigned mix_shift(input int unsigned dwlo, input int unsigned davr);
        return dwlo - davr;
    endfunction

endpackage

// File: rtl/mon_chan_cic.sv
// One channel: registered LO mixer, two free-running integrators, two combs at the strobe.
module mon_chan_cic
    import mon_pkg::*;
#(
    parameter int unsigned DWI  = 16,
    parameter int unsigned DWLO = 18,
    parameter int unsigned DAVR = 3,
    parameter int unsigned RWI  = 28
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   en_i,
    input  logic                   stb_i,
    input  logic signed [DWI-1:0]  adc_i,
    input  logic signed [DWLO-1:0] mlo_i,
    output logic [RWI-1:0]         res_o
);
    localparam int unsigned MW    = DWI + DAVR;
    localparam int unsigned PW    = DWI + DWLO;
    localparam int unsigned SHIFT = mix_shift(DWLO, DAVR);

    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] prod_sh;
    logic [MW-1:0]  mix_d, mix_q;
    logic [RWI-1:0] i1_d, i1_q, i2_d, i2_q;
    logic [RWI-1:0] i2_dly_d, i2_dly_q, c1_dly_d, c1_dly_q;
    logic [RWI-1:0] c1, c2;
    logic           unused_prod;

    assign prod        = adc_i * mlo_i;
    assign prod_sh     = prod >>> SHIFT;
    // Bits above MW are deliberately discarded by the truncating mixer.
    assign unused_prod = ^prod_sh[PW-1:MW];

    assign c1    = i2_q - i2_dly_q;
    assign c2    = c1 - c1_dly_q;
    assign res_o = c2;

    always_comb begin
        mix_d    = prod_sh[MW-1:0];
        i1_d     = i1_q + {{(RWI-MW){mix_q[MW-1]}}, mix_q};
        i2_d     = i2_q + i1_q;
        i2_dly_d = stb_i ? i2_q : i2_dly_q;
        c1_dly_d = stb_i ? c1 : c1_dly_q;
        if (!en_i) begin
            mix_d    = '0;
            i1_d     = '0;
            i2_d     = '0;
            i2_dly_d = '0;
            c1_dly_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mix_q    <= '0;
            i1_q     <= '0;
            i2_q     <= '0;
            i2_dly_q <= '0;
            c1_dly_q <= '0;
        end else begin
            mix_q    <= mix_d;
            i1_q     <= i1_d;
            i2_q     <= i2_d;
            i2_dly_q <= i2_dly_d;
            c1_dly_q <= c1_dly_d;
        end
    end

endmodule

// File: rtl/mon_chans_cic.sv
// Multi-channel mixer + CIC2 monitor: decimation strobe, result snapshot and valid/ready stream.
module mon_chans_cic
    import mon_pkg::*;
#(
    parameter int unsigned NCHAN    = 4,
    parameter int unsigned DWI      = 16,
    parameter int unsigned DWLO     = 18,
    parameter int unsigned DAVR     = 3,
    parameter int unsigned RWI      = 28,
    parameter int unsigned CW       = 12,
    parameter bit          EXT_SAMP = 1'b0,
    localparam int unsigned CHW     = chan_w(NCHAN)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NCHAN*DWI-1:0]    adc_i,
    input  logic [NCHAN*DWLO-1:0]   mlo_i,
    input  logic [CW-1:0]           period_i,
    input  logic                    samp_ext_i,
    input  logic [NCHAN-1:0]        chan_en_i,
    input  logic                    clr_ovr_i,
    output logic                    samp_out_o,
    output logic [RWI-1:0]          out_data_o,
    output logic [CHW-1:0]          out_chan_o,
    output logic                    out_valid_o,
    output logic                    out_last_o,
    input  logic                    out_ready_i,
    output logic                    ovr_o
);
    logic [NCHAN-1:0][RWI-1:0] res;
    logic [NCHAN-1:0][RWI-1:0] snap_d, snap_q;
    logic [NCHAN-1:0]          snap_en_d, snap_en_q;
    logic [CW-1:0]             cnt_d, cnt_q, per_d, per_q, per_eff;
    logic [CHW-1:0]            cur_d, cur_q, nxt, first;
    stream_state_e             state_d, state_q;
    logic                      ovr_d, ovr_q, samp_q;
    logic                      stb, stb_int, last, accept, free;

    for (genvar g = 0; g < NCHAN; g++) begin : g_chan
        mon_chan_cic #(
            .DWI  (DWI),
            .DWLO (DWLO),
            .DAVR (DAVR),
            .RWI  (RWI)
        ) u_chan (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .en_i   (chan_en_i[g]),
            .stb_i  (stb),
            .adc_i  (adc_i[g*DWI +: DWI]),
            .mlo_i  (mlo_i[g*DWLO +: DWLO]),
            .res_o  (res[g])
        );
    end

    // The period is captured on the first count of each interval, so mid-count edits wait.
    assign per_eff = (cnt_q == '0) ? period_i : per_q;
    assign stb_int = (cnt_q == per_eff);
    assign stb     = EXT_SAMP ? samp_ext_i : stb_int;
    assign cnt_d   = (stb_int || EXT_SAMP) ? '0 : cnt_q + CW'(1);
    assign per_d   = per_eff;

    always_comb begin
        last  = 1'b1;
        nxt   = cur_q;
        first = '0;
        for (int i = int'(NCHAN) - 1; i >= 0; i--) begin
            if (snap_en_q[i] && (i > int'(cur_q))) begin
                last = 1'b0;
                nxt  = CHW'(i);
            end
            if (chan_en_i[i]) begin
                first = CHW'(i);
            end
        end
    end

    assign accept = (state_q == StSend) && out_ready_i;
    assign free   = (state_q == StIdle) || (accept && last);

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        snap_d    = snap_q;
        snap_en_d = snap_en_q;
        ovr_d     = ovr_q & ~clr_ovr_i;
        if (accept) begin
            if (last) begin
                state_d = StIdle;
            end else begin
                cur_d = nxt;
            end
        end
        if (stb && (|chan_en_i)) begin
            if (free) begin
                state_d   = StSend;
                cur_d     = first;
                snap_d    = res;
                snap_en_d = chan_en_i;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            per_q     <= '0;
            state_q   <= StIdle;
            cur_q     <= '0;
            snap_q    <= '0;
            snap_en_q <= '0;
            ovr_q     <= 1'b0;
            samp_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            per_q     <= per_d;
            state_q   <= state_d;
            cur_q     <= cur_d;
            snap_q    <= snap_d;
            snap_en_q <= snap_en_d;
            ovr_q     <= ovr_d;
            samp_q    <= stb;
        end
    end

    assign out_valid_o = (state_q == StSend);
    assign out_chan_o  = out_valid_o ? cur_q : '0;
    assign out_data_o  = out_valid_o ? snap_q[cur_q] : '0;
    assign out_last_o  = out_valid_o && last;
    assign samp_out_o  = samp_q;
    assign ovr_o       = ovr_q;

endmodule
